sym_vn_lut_pipe: RTL and testbench
==================================

# sym_vn_lut_pipe

Parametrised, multi-channel successor to the two-port symmetric variable-node LUT output stage. Each of `CHANNELS` lanes folds an incoming message pair (y0, y1) onto the half-size symmetric table and reads the table. It then restores the sign and returns the V2C message `t_c` plus the raw table word for the next decision node. The block has valid/stall handshaking and an internal multi-set LUT written on the same clock. It sits between the VN message buffers and the decision/CN stages of the layered decoder.

## Interface
- `QUAN_SIZE`, 4: message width in bits (≥2).
- `CHANNELS`, 2: number of independent read lanes.
- `LUT_SETS`, 2: number of LUT sets (iteration-dependent tables); `SET_W = max(1,$clog2(LUT_SETS))`.
- `ADDR_W`, derived `2*QUAN_SIZE-1`: per-set table address width; depth `2**ADDR_W`.
- `read_clk` in 1: the single clock; reads and writes both use it.
- `rstn` in 1: reset, synchronous and active-low.
- `in_valid` in CHANNELS: per-lane input qualifier.
- `pipe_en` in 1: global advance enable; 0 freezes every pipeline register.
- `transpose_en_in` in CHANNELS: per-lane transpose request.
- `y0_in`, `y1_in` in CHANNELS*QUAN_SIZE each: packed lane messages; lane k occupies bits `[k*QUAN_SIZE +: QUAN_SIZE]`.
- `read_set` in SET_W: LUT set for the current input beat, shared by all lanes.
- `t_c` out CHANNELS*QUAN_SIZE: sign-restored output message.
- `t_c_din` out CHANNELS*QUAN_SIZE: raw LUT word, without complement.
- `transpose_en_out` out CHANNELS: folded MSB delayed to the output; drives the next decision node.
- `out_valid` out CHANNELS: output qualifier.
- `read_set_out` out SET_W: `read_set` delayed to the output.
- `we` in 1: LUT write strobe.
- `write_set` in SET_W, `write_addr` in ADDR_W, `write_data` in QUAN_SIZE: LUT write port, one entry per cycle.

## Operation
- **Fold (combinational, per lane):**
  - `msb = y0[Q-1] ^ transpose_en_in`.
  - `y1f = msb ? ~y1 : y1`.
  - `addr = {y0[Q-2:0], y1f}`.
- **Stage 0 register:** captures `addr`, `msb`, `in_valid`, `read_set` when `pipe_en`.
- **LUT read:** lane k reads `mem[read_set_p0][addr_p0]`.
  - Read port count equals `CHANNELS`.
  - Stage 1 register captures the data, `msb` and valid when `pipe_en`.
- **Output (combinational from stage 1):**
  - `t_c = msb_p1 ? ~data_p1 : data_p1`.
  - `t_c_din = data_p1`.
  - `transpose_en_out = msb_p1`.
- **Valid handling:**
  - An invalid lane still propagates data (don't-care).
  - Only `out_valid` is meaningful.
- **Write port:**
  - On `we && rstn`, `mem[write_set][write_addr] <= write_data` at the clock edge.
  - Writes are independent of `pipe_en`.
- **Read/write collision** (same set and address in the same cycle): the read returns the old data (read-first). The new data is visible from the next cycle.
- **Out-of-range set:** `read_set` or `write_set ≥ LUT_SETS` reads 0, and writes to it are ignored.

## Timing
- Latency is 2 cycles from input capture to output when `pipe_en` is held at 1. With `SYM_VN_OUT_REG_EN` it is 3 cycles.
- Throughput: one beat per lane per cycle.
- `pipe_en=0`: all stages hold and outputs stay stable. Inputs presented during the stall are not captured.
- **Reset (`rstn=0` at an edge):**
  - All pipeline registers clear to 0, so `t_c`, `t_c_din`, `transpose_en_out`, `out_valid` and `read_set_out` are all 0.
  - In-flight beats are discarded, including on a mid-stream reset.
  - `we` is ignored while `rstn=0`.
  - LUT contents are not reset; software rewrites them before use.
- Reset has priority over `pipe_en`.
- The first valid output appears exactly the latency in cycles after the first capturing edge following reset release.

## Configuration
- `SYM_VN_OUT_REG_EN` defined: adds a stage-2 register on `t_c`, `t_c_din`, `transpose_en_out`, `out_valid` and `read_set_out`.
  - The register is gated by `pipe_en` and reset to 0.
  - Latency becomes 3.
- Undefined: outputs are combinational from stage 1; latency is 2.

## Structure
- Shared package `sym_vn_pkg` holds:
  - the default `QUAN_SIZE`, `CHANNELS` and `LUT_SETS` constants;
  - the `SET_W`/`ADDR_W` derivation functions;
  - a fold function returning `{msb, addr}`.
- Sub-module `sym_vn_lut_mem`: `LUT_SETS × 2**ADDR_W × QUAN_SIZE` array with `CHANNELS` synchronous read-first read ports and one write port. The top instantiates it once.

## Test plan
(Q=4, CH=2, SETS=2, no macro unless stated.)
- **Basic read:** write set0 addr 7'h53 data 4'b0110. Lane0 y0=4'b0101, y1=4'b0011, tr=0, valid. After 2 cycles: `t_c=0110`, `t_c_din=0110`, `transpose_en_out=0`, `out_valid=1`.
- **Symmetric fold:**
  - Lane1 y0=4'b1101, y1=4'b1100, tr=0 (same address 0x53): `t_c=1001`, `t_c_din=0110`, `transpose_en_out=1`.
  - Lane0 y0=4'b0101, y1=4'b1100, tr=1: same result.
- **Set select:** set1 addr 0x53 = 4'b1111, set0 = 4'b0110. Alternate `read_set` 0/1 each cycle → `t_c` alternates 0110/1111 and `read_set_out` follows with 2 cycles of delay.
- **Stall:** stream 4 valid beats, drop `pipe_en` for 3 cycles mid-stream → outputs frozen during the stall; no beat lost or duplicated; order preserved.
- **Collision:** write 0x53 = 4'b0001 in the same cycle as a read of 0x53 (old 0110) → that beat returns 0110; a read one cycle later returns 0001.
- **Reset mid-stream:** `rstn=0` for 1 cycle with 2 beats in flight → all outputs 0 next cycle; `out_valid` is 0 until a new beat traverses. Repeat with `SYM_VN_OUT_REG_EN` to confirm latency 3.

Source files
------------

// File: rtl/sym_vn_pkg.sv
// Shared defaults, width helpers and the symmetric fold for the VN LUT pipeline.
package sym_vn_pkg;
    localparam int DEF_QUAN_SIZE = 4;
    localparam int DEF_CHANNELS  = 2;
    localparam int DEF_LUT_SETS  = 2;
    // Widest message the fold helper supports; QUAN_SIZE must not exceed it.
    localparam int FOLD_MAX_Q    = 16;
    localparam int FOLD_W        = 2 * FOLD_MAX_Q;

    function automatic int calc_set_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int calc_addr_w(input int quan);
        return 2 * quan - 1;
    endfunction

    // Result is right-aligned: msb at bit 2*quan-1, table address below it.
    function automatic logic [FOLD_W-1:0] fold_msg(
        input logic [FOLD_MAX_Q-1:0] y0,
        input logic [FOLD_MAX_Q-1:0] y1,
        input logic                  tr,
        input int                    quan
    );
        logic [FOLD_MAX_Q-1:0] y0_top;
        logic [FOLD_MAX_Q-1:0] y1_f;
        logic [FOLD_W-1:0]     lo_mask;
        logic [FOLD_W-1:0]     msb_w;
        logic                  msb;
        y0_top  = y0 >> (quan - 1);
        msb     = y0_top[0] ^ tr;
        y1_f    = msb ? ~y1 : y1;
        lo_mask = {{FOLD_MAX_Q{1'b0}}, {FOLD_MAX_Q{1'b1}}} >> (FOLD_MAX_Q - quan);
        msb_w   = {{(FOLD_W-1){1'b0}}, msb};
        return (msb_w << (2 * quan - 1))
             | (({{FOLD_MAX_Q{1'b0}}, y0} & (lo_mask >> 1)) << quan)
             | ({{FOLD_MAX_Q{1'b0}}, y1_f} & lo_mask);
    endfunction
endpackage

// File: rtl/sym_vn_lut_mem.sv
// Multi-set symmetric LUT: CHANNELS registered read-first read ports, one write port.
module sym_vn_lut_mem
    import sym_vn_pkg::*;
#(
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int LUT_SETS  = DEF_LUT_SETS,
    parameter int SET_W     = calc_set_w(DEF_LUT_SETS),
    parameter int ADDR_W    = calc_addr_w(DEF_QUAN_SIZE)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rd_en,
    input  logic [SET_W-1:0]              rd_set,
    input  logic [CHANNELS*ADDR_W-1:0]    rd_addr,
    output logic [CHANNELS*QUAN_SIZE-1:0] rd_data,
    input  logic                          wr_en,
    input  logic [SET_W-1:0]              wr_set,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [QUAN_SIZE-1:0]          wr_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [QUAN_SIZE-1:0]          mem_q [LUT_SETS][DEPTH];
    logic [CHANNELS*QUAN_SIZE-1:0] rd_data_d;
    logic [CHANNELS*QUAN_SIZE-1:0] rd_data_q;
    logic                          rd_set_ok;
    logic                          wr_set_ok;

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_comb begin
        rd_set_ok = int'(rd_set) < LUT_SETS;
        wr_set_ok = int'(wr_set) < LUT_SETS;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                rd_data_d[k*QUAN_SIZE +: QUAN_SIZE] =
                    rd_set_ok ? mem_q[rd_set][rd_addr[k*ADDR_W +: ADDR_W]] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en && wr_set_ok) begin
            mem_q[wr_set][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/sym_vn_lut_pipe.sv
// Multi-lane symmetric VN LUT output stage: fold, table read, sign restore.
// Optional macro SYM_VN_OUT_REG_EN adds an output register stage (latency 3).
module sym_vn_lut_pipe
    import sym_vn_pkg::*;
#(
    parameter  int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter  int CHANNELS  = DEF_CHANNELS,
    parameter  int LUT_SETS  = DEF_LUT_SETS,
    localparam int SET_W     = calc_set_w(LUT_SETS),
    localparam int ADDR_W    = calc_addr_w(QUAN_SIZE)
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    input  logic [CHANNELS-1:0]           in_valid,
    input  logic                          pipe_en,
    input  logic [CHANNELS-1:0]           transpose_en_in,
    input  logic [CHANNELS*QUAN_SIZE-1:0] y0_in,
    input  logic [CHANNELS*QUAN_SIZE-1:0] y1_in,
    input  logic [SET_W-1:0]              read_set,
    output logic [CHANNELS*QUAN_SIZE-1:0] t_c,
    output logic [CHANNELS*QUAN_SIZE-1:0] t_c_din,
    output logic [CHANNELS-1:0]           transpose_en_out,
    output logic [CHANNELS-1:0]           out_valid,
    output logic [SET_W-1:0]              read_set_out,
    input  logic                          we,
    input  logic [SET_W-1:0]              write_set,
    input  logic [ADDR_W-1:0]             write_addr,
    input  logic [QUAN_SIZE-1:0]          write_data
);
    logic [CHANNELS-1:0][FOLD_W-1:0] fold_res;
    logic [FOLD_MAX_Q-1:0]           y0_ext;
    logic [FOLD_MAX_Q-1:0]           y1_ext;
    logic                            fold_unused;

    logic [CHANNELS*ADDR_W-1:0]    addr_p0_d, addr_p0_q;
    logic [CHANNELS-1:0]           msb_p0_d, msb_p0_q;
    logic [CHANNELS-1:0]           valid_p0_d, valid_p0_q;
    logic [SET_W-1:0]              set_p0_d, set_p0_q;
    logic [CHANNELS-1:0]           msb_p1_d, msb_p1_q;
    logic [CHANNELS-1:0]           valid_p1_d, valid_p1_q;
    logic [SET_W-1:0]              set_p1_d, set_p1_q;
    logic [CHANNELS*QUAN_SIZE-1:0] data_p1;
    logic [CHANNELS*QUAN_SIZE-1:0] t_c_s1;

    always_comb begin
        fold_res   = '0;
        y0_ext     = '0;
        y1_ext     = '0;
        addr_p0_d  = addr_p0_q;
        msb_p0_d   = msb_p0_q;
        valid_p0_d = valid_p0_q;
        set_p0_d   = set_p0_q;
        for (int k = 0; k < CHANNELS; k++) begin
            y0_ext                        = '0;
            y1_ext                        = '0;
            y0_ext[QUAN_SIZE-1:0]         = y0_in[k*QUAN_SIZE +: QUAN_SIZE];
            y1_ext[QUAN_SIZE-1:0]         = y1_in[k*QUAN_SIZE +: QUAN_SIZE];
            fold_res[k]                   = fold_msg(y0_ext, y1_ext, transpose_en_in[k], QUAN_SIZE);
            if (pipe_en) begin
                addr_p0_d[k*ADDR_W +: ADDR_W] = fold_res[k][ADDR_W-1:0];
                msb_p0_d[k]                   = fold_res[k][ADDR_W];
            end
        end
        if (pipe_en) begin
            valid_p0_d = in_valid;
            set_p0_d   = read_set;
        end
        msb_p1_d   = pipe_en ? msb_p0_q   : msb_p1_q;
        valid_p1_d = pipe_en ? valid_p0_q : valid_p1_q;
        set_p1_d   = pipe_en ? set_p0_q   : set_p1_q;
    end

    assign fold_unused = ^fold_res;

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            addr_p0_q  <= '0;
            msb_p0_q   <= '0;
            valid_p0_q <= '0;
            set_p0_q   <= '0;
            msb_p1_q   <= '0;
            valid_p1_q <= '0;
            set_p1_q   <= '0;
        end else begin
            addr_p0_q  <= addr_p0_d;
            msb_p0_q   <= msb_p0_d;
            valid_p0_q <= valid_p0_d;
            set_p0_q   <= set_p0_d;
            msb_p1_q   <= msb_p1_d;
            valid_p1_q <= valid_p1_d;
            set_p1_q   <= set_p1_d;
        end
    end

    // The memory's read register doubles as the stage-1 data register.
    sym_vn_lut_mem #(
        .QUAN_SIZE (QUAN_SIZE),
        .CHANNELS  (CHANNELS),
        .LUT_SETS  (LUT_SETS),
        .SET_W     (SET_W),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk     (read_clk),
        .rstn    (rstn),
        .rd_en   (pipe_en),
        .rd_set  (set_p0_q),
        .rd_addr (addr_p0_q),
        .rd_data (data_p1),
        .wr_en   (we),
        .wr_set  (write_set),
        .wr_addr (write_addr),
        .wr_data (write_data)
    );

    always_comb begin
        t_c_s1 = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            t_c_s1[k*QUAN_SIZE +: QUAN_SIZE] = msb_p1_q[k] ? ~data_p1[k*QUAN_SIZE +: QUAN_SIZE]
                                                           :  data_p1[k*QUAN_SIZE +: QUAN_SIZE];
        end
    end

`ifdef SYM_VN_OUT_REG_EN
    logic [CHANNELS*QUAN_SIZE-1:0] t_c_out_d, t_c_out_q;
    logic [CHANNELS*QUAN_SIZE-1:0] din_out_d, din_out_q;
    logic [CHANNELS-1:0]           tr_out_d, tr_out_q;
    logic [CHANNELS-1:0]           valid_out_d, valid_out_q;
    logic [SET_W-1:0]              set_out_d, set_out_q;

    always_comb begin
        t_c_out_d   = pipe_en ? t_c_s1     : t_c_out_q;
        din_out_d   = pipe_en ? data_p1    : din_out_q;
        tr_out_d    = pipe_en ? msb_p1_q   : tr_out_q;
        valid_out_d = pipe_en ? valid_p1_q : valid_out_q;
        set_out_d   = pipe_en ? set_p1_q   : set_out_q;
    end

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            t_c_out_q   <= '0;
            din_out_q   <= '0;
            tr_out_q    <= '0;
            valid_out_q <= '0;
            set_out_q   <= '0;
        end else begin
            t_c_out_q   <= t_c_out_d;
            din_out_q   <= din_out_d;
            tr_out_q    <= tr_out_d;
            valid_out_q <= valid_out_d;
            set_out_q   <= set_out_d;
        end
    end

    assign t_c              = t_c_out_q;
    assign t_c_din          = din_out_q;
    assign transpose_en_out = tr_out_q;
    assign out_valid        = valid_out_q;
    assign read_set_out     = set_out_q;
`else
    assign t_c              = t_c_s1;
    assign t_c_din          = data_p1;
    assign transpose_en_out = msb_p1_q;
    assign out_valid        = valid_p1_q;
    assign read_set_out     = set_p1_q;
`endif
endmodule

// File: tb/tb_sym_vn_lut_pipe.sv
// Directed bench for sym_vn_lut_pipe (Q=4, CH=2, SETS=2); honours SYM_VN_OUT_REG_EN.
`timescale 1ns/1ps
module tb_sym_vn_lut_pipe;
`ifdef SYM_VN_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       read_clk = 1'b0;
    logic       rstn;
    logic [1:0] in_valid;
    logic       pipe_en;
    logic [1:0] transpose_en_in;
    logic [7:0] y0_in;
    logic [7:0] y1_in;
    logic       read_set;
    logic [7:0] t_c;
    logic [7:0] t_c_din;
    logic [1:0] transpose_en_out;
    logic [1:0] out_valid;
    logic       read_set_out;
    logic       we;
    logic       write_set;
    logic [6:0] write_addr;
    logic [3:0] write_data;

    int checks = 0;
    int errors = 0;

    logic [3:0] sel_tc     [4] = '{4'b0110, 4'b1111, 4'b0110, 4'b1111};
    logic       sel_set    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] stall_data [4] = '{4'h9, 4'h3, 4'hC, 4'h5};
    logic       pe_tab     [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 read_clk = ~read_clk;

    sym_vn_lut_pipe dut (
        .read_clk         (read_clk),
        .rstn             (rstn),
        .in_valid         (in_valid),
        .pipe_en          (pipe_en),
        .transpose_en_in  (transpose_en_in),
        .y0_in            (y0_in),
        .y1_in            (y1_in),
        .read_set         (read_set),
        .t_c              (t_c),
        .t_c_din          (t_c_din),
        .transpose_en_out (transpose_en_out),
        .out_valid        (out_valid),
        .read_set_out     (read_set_out),
        .we               (we),
        .write_set        (write_set),
        .write_addr       (write_addr),
        .write_data       (write_data)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge read_clk);
            #1;
        end
    endtask

    task automatic set_lane(input int k, input logic [3:0] y0, input logic [3:0] y1,
                            input logic tr, input logic v);
        y0_in[k*4 +: 4]    = y0;
        y1_in[k*4 +: 4]    = y1;
        transpose_en_in[k] = tr;
        in_valid[k]        = v;
    endtask

    task automatic write_lut(input logic s, input logic [6:0] a, input logic [3:0] d);
        we         = 1'b1;
        write_set  = s;
        write_addr = a;
        write_data = d;
        tick(1);
        we         = 1'b0;
    endtask

    task automatic test_reset;
        rstn     = 1'b0;
        pipe_en  = 1'b1;
        set_lane(0, 4'b1010, 4'b0101, 1'b1, 1'b1);
        set_lane(1, 4'b1111, 4'b0000, 1'b0, 1'b1);
        read_set = 1'b1;
        tick(2);
        checks++; if (t_c !== 8'h00) begin errors++; $display("[TB] FAIL reset_t_c actual=%h required=%h", t_c, 8'h00); end
        checks++; if (t_c_din !== 8'h00) begin errors++; $display("[TB] FAIL reset_t_c_din actual=%h required=%h", t_c_din, 8'h00); end
        checks++; if (transpose_en_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_tr_out actual=%b required=%b", transpose_en_out, 2'b00); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_valid actual=%b required=%b", out_valid, 2'b00); end
        checks++; if (read_set_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_set_out actual=%b required=%b", read_set_out, 1'b0); end
        in_valid = 2'b00;
        read_set = 1'b0;
        rstn     = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_read;
        write_lut(1'b0, 7'h53, 4'b0110);
        write_lut(1'b1, 7'h53, 4'b1111);
        set_lane(0, 4'b0101, 4'b0011, 1'b0, 1'b1);
        set_lane(1, 4'b1101, 4'b1100, 1'b0, 1'b1);
        read_set = 1'b0;
        tick(1);
        in_valid = 2'b00;
        tick(LAT - 1);
        checks++; if (t_c !== 8'h96) begin errors++; $display("[TB] FAIL basic_t_c actual=%h required=%h", t_c, 8'h96); end
        checks++; if (t_c_din !== 8'h66) begin errors++; $display("[TB] FAIL basic_t_c_din actual=%h required=%h", t_c_din, 8'h66); end
        checks++; if (transpose_en_out !== 2'b10) begin errors++; $display("[TB] FAIL basic_tr_out actual=%b required=%b", transpose_en_out, 2'b10); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("[TB] FAIL basic_out_valid actual=%b required=%b", out_valid, 2'b11); end
        tick(1);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL basic_valid_drop actual=%b required=%b", out_valid, 2'b00); end
    endtask

    task automatic test_transpose;
        set_lane(0, 4'b0101, 4'b1100, 1'b1, 1'b1);
        set_lane(1, 4'b1101, 4'b0011, 1'b1, 1'b1);
        read_set = 1'b0;
        tick(1);
        in_valid = 2'b00;
        tick(LAT - 1);
        checks++; if (t_c !== 8'h69) begin errors++; $display("[TB] FAIL transpose_t_c actual=%h required=%h", t_c, 8'h69); end
        checks++; if (t_c_din !== 8'h66) begin errors++; $display("[TB] FAIL transpose_t_c_din actual=%h required=%h", t_c_din, 8'h66); end
        checks++; if (transpose_en_out !== 2'b01) begin errors++; $display("[TB] FAIL transpose_tr_out actual=%b required=%b", transpose_en_out, 2'b01); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("[TB] FAIL transpose_out_valid actual=%b required=%b", out_valid, 2'b11); end
        transpose_en_in = 2'b00;
    endtask

    task automatic test_set_select;
        int j;
        set_lane(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            if (i < 4) begin
                set_lane(0, 4'b0101, 4'b0011, 1'b0, 1'b1);
                read_set = sel_set[i];
            end else begin
                in_valid = 2'b00;
            end
            tick(1);
            j = i - (LAT - 1);
            if (j >= 0) begin
                checks++; if (out_valid !== 2'b01) begin errors++; $display("[TB] FAIL set_sel_valid[%0d] actual=%b required=%b", j, out_valid, 2'b01); end
                checks++; if (t_c[3:0] !== sel_tc[j]) begin errors++; $display("[TB] FAIL set_sel_t_c[%0d] actual=%b required=%b", j, t_c[3:0], sel_tc[j]); end
                checks++; if (read_set_out !== sel_set[j]) begin errors++; $display("[TB] FAIL set_sel_rso[%0d] actual=%b required=%b", j, read_set_out, sel_set[j]); end
            end
        end
        in_valid = 2'b00;
        read_set = 1'b0;
        tick(1);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL set_sel_drain actual=%b required=%b", out_valid, 2'b00); end
    endtask

    task automatic test_stall;
        int adv;
        int nb;
        int j;
        logic exp_v;
        for (int a = 0; a < 4; a++) begin
            write_lut(1'b0, 7'(a), stall_data[a]);
        end
        adv = 0;
        nb  = 0;
        set_lane(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        read_set = 1'b0;
        for (int e = 0; e < 10; e++) begin
            pipe_en = pe_tab[e];
            if (pe_tab[e] && nb < 4) begin
                set_lane(0, 4'b0000, 4'(nb), 1'b0, 1'b1);
                nb++;
            end else if (!pe_tab[e]) begin
                set_lane(0, 4'b0000, 4'd2, 1'b0, 1'b1);
            end else begin
                in_valid[0] = 1'b0;
            end
            tick(1);
            if (pe_tab[e]) adv++;
            j     = adv - LAT;
            exp_v = (j >= 0) && (j < 4);
            checks++; if (out_valid !== {1'b0, exp_v}) begin errors++; $display("[TB] FAIL stall_valid[e%0d] actual=%b required=%b", e, out_valid, {1'b0, exp_v}); end
            if (exp_v) begin
                checks++; if (t_c[3:0] !== stall_data[j]) begin errors++; $display("[TB] FAIL stall_t_c[e%0d] actual=%h required=%h", e, t_c[3:0], stall_data[j]); end
            end
        end
        pipe_en  = 1'b1;
        in_valid = 2'b00;
    endtask

    task automatic test_collision;
        set_lane(0, 4'b0101, 4'b0011, 1'b0, 1'b1);
        in_valid[1] = 1'b0;
        read_set    = 1'b0;
        tick(1);
        we         = 1'b1;
        write_set  = 1'b0;
        write_addr = 7'h53;
        write_data = 4'b0001;
        tick(1);
        we       = 1'b0;
        in_valid = 2'b00;
        tick(LAT - 2);
        checks++; if (t_c[3:0] !== 4'b0110 || out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL collision_old actual=%b/%b required=%b/1", t_c[3:0], out_valid[0], 4'b0110); end
        tick(1);
        checks++; if (t_c[3:0] !== 4'b0001 || out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL collision_new actual=%b/%b required=%b/1", t_c[3:0], out_valid[0], 4'b0001); end
        tick(1);
        write_lut(1'b0, 7'h53, 4'b0110);
    endtask

    task automatic test_reset_mid;
        set_lane(0, 4'b0101, 4'b0011, 1'b0, 1'b1);
        set_lane(1, 4'b1101, 4'b1100, 1'b0, 1'b1);
        read_set = 1'b1;
        tick(2);
        rstn    = 1'b0;
        pipe_en = 1'b0;
        tick(1);
        checks++; if (t_c !== 8'h00) begin errors++; $display("[TB] FAIL midrst_t_c actual=%h required=%h", t_c, 8'h00); end
        checks++; if (t_c_din !== 8'h00) begin errors++; $display("[TB] FAIL midrst_t_c_din actual=%h required=%h", t_c_din, 8'h00); end
        checks++; if (transpose_en_out !== 2'b00) begin errors++; $display("[TB] FAIL midrst_tr_out actual=%b required=%b", transpose_en_out, 2'b00); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_out_valid actual=%b required=%b", out_valid, 2'b00); end
        checks++; if (read_set_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_read_set_out actual=%b required=%b", read_set_out, 1'b0); end
        rstn     = 1'b1;
        pipe_en  = 1'b1;
        in_valid = 2'b00;
        read_set = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            tick(1);
            checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flush[%0d] actual=%b required=%b", c, out_valid, 2'b00); end
        end
        set_lane(0, 4'b0101, 4'b1100, 1'b1, 1'b1);
        in_valid[1] = 1'b0;
        tick(1);
        in_valid = 2'b00;
        tick(LAT - 2);
        checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_early actual=%b required=%b", out_valid, 2'b00); end
        tick(1);
        checks++; if (out_valid !== 2'b01) begin errors++; $display("[TB] FAIL midrst_first_valid actual=%b required=%b", out_valid, 2'b01); end
        checks++; if (t_c[3:0] !== 4'b1001 || transpose_en_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL midrst_first_data actual=%b/%b required=1001/1", t_c[3:0], transpose_en_out[0]); end
        transpose_en_in = 2'b00;
    endtask

    task automatic test_reset_we;
        write_lut(1'b0, 7'h11, 4'b0101);
        rstn       = 1'b0;
        we         = 1'b1;
        write_set  = 1'b0;
        write_addr = 7'h11;
        write_data = 4'b1010;
        tick(1);
        we   = 1'b0;
        rstn = 1'b1;
        set_lane(0, 4'b0001, 4'b0001, 1'b0, 1'b1);
        in_valid[1] = 1'b0;
        read_set    = 1'b0;
        tick(1);
        in_valid = 2'b00;
        tick(LAT - 1);
        checks++; if (t_c[3:0] !== 4'b0101 || out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL reset_we_ignored actual=%b/%b required=0101/1", t_c[3:0], out_valid[0]); end
    endtask

    initial begin
        rstn            = 1'b0;
        in_valid        = 2'b00;
        pipe_en         = 1'b1;
        transpose_en_in = 2'b00;
        y0_in           = 8'h00;
        y1_in           = 8'h00;
        read_set        = 1'b0;
        we              = 1'b0;
        write_set       = 1'b0;
        write_addr      = 7'h00;
        write_data      = 4'h0;
        $display("[TB] latency under test = %0d", LAT);
        test_reset();
        test_basic_read();
        test_transpose();
        test_set_select();
        test_stall();
        test_collision();
        test_reset_mid();
        test_reset_we();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
